// File: rtl/a_block_writer.sv
// Ping-pong HASH RAM block writer: streams A-matrix words into two banks, signals hash_ready.
// Optional A_BLOCK_WRITER_PERF_EN adds the stall_cnt back-pressure counter.
//
// state | meaning
// IDLE  | no job; waits for start
// FILL  | accepting stream words into the current write bank
// WAIT  | all words written; waits for the consumer to release every bank
module a_block_writer #(
    parameter int WORDS_PER_ROW  = 336,
    parameter int ROWS_PER_BLOCK = 4,
    parameter int BASE_ADDR      = 0,
    parameter int ADDR_W         = 32,
    parameter int BANK_WORDS     = WORDS_PER_ROW * ROWS_PER_BLOCK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [9:0]        num_blocks,
    input  logic              s_valid,
    input  logic [63:0]       s_data,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              hash_ready,
    output logic              rd_bank,
    input  logic              block_done,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef A_BLOCK_WRITER_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int IDX_W = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]       state;
    logic             wr_bank;
    logic             bank_pend;
    logic [1:0]       full_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [9:0]       blk_cnt;
    logic [9:0]       nblocks;
    logic [2:0]       occ;
    logic             handshake;
    logic             last_word;
    logic             release_ok;
    logic             start_ok;

    // A bank whose last word was just accepted is counted as occupied so
    // the next word can never land in a bank the consumer still owns.
    assign occ        = {1'b0, full_cnt} + {2'b00, bank_pend};
    assign s_ready    = (state == S_FILL) && (occ < 3'd2);
    assign handshake  = s_valid && s_ready;
    assign last_word  = (word_idx == IDX_W'(BANK_WORDS - 1));
    assign release_ok = block_done && (full_cnt != 2'd0);
    assign start_ok   = start && (state == S_IDLE);
    assign hash_ready = (full_cnt != 2'd0);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_pend <= 1'b0;
            full_cnt  <= 2'd0;
            word_idx  <= '0;
            blk_cnt   <= 10'd0;
            nblocks   <= 10'd0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 64'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done      <= 1'b0;
            bank_pend <= 1'b0;
            wr_en     <= handshake;
            if (handshake) begin
                wr_data <= s_data;
                wr_addr <= ADDR_W'(BASE_ADDR)
                         + (wr_bank ? ADDR_W'(BANK_WORDS) : {ADDR_W{1'b0}})
                         + ADDR_W'(word_idx);
            end

            // Completion lands one edge after the final write is presented.
            case ({bank_pend, release_ok})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
            if (release_ok)
                rd_bank <= ~rd_bank;
            if (block_done && (full_cnt == 2'd0))
                err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (num_blocks == 10'd0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= S_FILL;
                            nblocks  <= num_blocks;
                            word_idx <= '0;
                            blk_cnt  <= 10'd0;
                            wr_bank  <= 1'b0;
                            rd_bank  <= 1'b0;
                            full_cnt <= 2'd0;
                        end
                    end
                end
                S_FILL: begin
                    if (handshake) begin
                        if (last_word) begin
                            word_idx  <= '0;
                            wr_bank   <= ~wr_bank;
                            bank_pend <= 1'b1;
                            blk_cnt   <= blk_cnt + 10'd1;
                            if (blk_cnt == nblocks - 10'd1)
                                state <= S_WAIT;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if ((full_cnt == 2'd0) && !bank_pend) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef A_BLOCK_WRITER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 32'd0;
        else if (start_ok)
            stall_cnt <= 32'd0;
        else if ((state == S_FILL) && s_valid && !s_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_a_block_writer.sv
// Directed bench for a_block_writer with an 8-word bank (4 words x 2 rows) at 0x100.
module tb_a_block_writer;

    localparam int AW = 32;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic [9:0]    num_blocks = 10'd0;
    logic          s_valid    = 1'b0;
    logic [63:0]   s_data     = 64'd0;
    logic          block_done = 1'b0;
    logic          s_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          hash_ready;
    logic          rd_bank;
    logic          busy;
    logic          done;
    logic          err;
`ifdef A_BLOCK_WRITER_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    a_block_writer #(
        .WORDS_PER_ROW (4),
        .ROWS_PER_BLOCK(2),
        .BASE_ADDR     (32'h100),
        .ADDR_W        (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_blocks(num_blocks),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .hash_ready(hash_ready),
        .rd_bank   (rd_bank),
        .block_done(block_done),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef A_BLOCK_WRITER_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (2) step();
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_hash_ready", 64'(hash_ready), 64'd0);
        check("rst_rd_bank", 64'(rd_bank), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // single block, continuous valid
        start = 1'b1; num_blocks = 10'd1;
        step();
        start = 1'b0;
        check("s1_busy", 64'(busy), 64'd1);
        check("s1_ready", 64'(s_ready), 64'd1);
        check("s1_wr_en_idle", 64'(wr_en), 64'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 64'(i);
            step();
            check("s1_wr_en", 64'(wr_en), 64'd1);
            check("s1_addr", 64'(wr_addr), 64'(32'h100 + i));
            check("s1_data", wr_data, 64'(i));
            check("s1_hr_low", 64'(hash_ready), 64'd0);
            check("s1_ready_run", 64'(s_ready), (i < 7) ? 64'd1 : 64'd0);
        end
        s_valid = 1'b0;
        step();
        check("s1_wr_en_off", 64'(wr_en), 64'd0);
        check("s1_hr_rise", 64'(hash_ready), 64'd1);
        check("s1_rd_bank", 64'(rd_bank), 64'd0);
        check("s1_done_early", 64'(done), 64'd0);
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        check("s1_hr_fall", 64'(hash_ready), 64'd0);
        check("s1_rd_toggle", 64'(rd_bank), 64'd1);
        check("s1_done_wait", 64'(done), 64'd0);
        step();
        check("s1_done", 64'(done), 64'd1);
        check("s1_busy_fall", 64'(busy), 64'd0);
        step();
        check("s1_done_pulse", 64'(done), 64'd0);

        // block_done with nothing resident
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        check("err_set", 64'(err), 64'd1);
        step();
        check("err_sticky", 64'(err), 64'd1);
        check("err_no_toggle", 64'(rd_bank), 64'd1);
        check("err_hr", 64'(hash_ready), 64'd0);

        // num_blocks == 0, also clears err
        start = 1'b1; num_blocks = 10'd0;
        step();
        start = 1'b0;
        check("z_done", 64'(done), 64'd1);
        check("z_busy", 64'(busy), 64'd0);
        check("z_wr_en", 64'(wr_en), 64'd0);
        check("z_err_clr", 64'(err), 64'd0);
        step();
        check("z_done_pulse", 64'(done), 64'd0);
        check("z_busy_after", 64'(busy), 64'd0);

        // three blocks, block_done withheld
        start = 1'b1; num_blocks = 10'd3;
        step();
        start = 1'b0;
        check("s2_rd_bank", 64'(rd_bank), 64'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 64'(i);
            step();
            check("s2_wr_en", 64'(wr_en), 64'd1);
            check("s2_addr", 64'(wr_addr), 64'(32'h100 + i));
            check("s2_data", wr_data, 64'(i));
        end
        check("s2_ready_drop", 64'(s_ready), 64'd0);
        check("s2_hr", 64'(hash_ready), 64'd1);
        s_data = 64'd16;
        for (int k = 0; k < 5; k++) begin
            step();
            check("s2_stall_wr", 64'(wr_en), 64'd0);
            check("s2_stall_ready", 64'(s_ready), 64'd0);
        end
`ifdef A_BLOCK_WRITER_PERF_EN
        check("s2_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        check("s2_rd_bank_rel", 64'(rd_bank), 64'd1);
        check("s2_ready_back", 64'(s_ready), 64'd1);
        check("s2_no_wr_rel", 64'(wr_en), 64'd0);
        check("s2_hr_keep", 64'(hash_ready), 64'd1);
        for (int i = 16; i < 24; i++) begin
            s_data = 64'(i);
            step();
            check("s2_b2_wr_en", 64'(wr_en), 64'd1);
            check("s2_b2_addr", 64'(wr_addr), 64'(32'h100 + i - 16));
            check("s2_b2_data", wr_data, 64'(i));
        end
        s_valid = 1'b0;
        step();
        check("s2_wait_hr", 64'(hash_ready), 64'd1);
        check("s2_wait_busy", 64'(busy), 64'd1);
        check("s2_wait_ready", 64'(s_ready), 64'd0);
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        check("s2_rel1_bank", 64'(rd_bank), 64'd0);
        check("s2_rel1_hr", 64'(hash_ready), 64'd1);
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        check("s2_rel2_hr", 64'(hash_ready), 64'd0);
        check("s2_rel2_bank", 64'(rd_bank), 64'd1);
        check("s2_rel2_done", 64'(done), 64'd0);
        step();
        check("s2_done", 64'(done), 64'd1);
        check("s2_busy_fall", 64'(busy), 64'd0);

        // simultaneous completion and release, start ignored mid-FILL
        start = 1'b1; num_blocks = 10'd3;
        step();
        start = 1'b0;
        num_blocks = 10'd0;
        s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 64'h5A00 + 64'(i);
            start = (i == 10);
            step();
            check("s3_addr", 64'(wr_addr), 64'(32'h100 + i));
            check("s3_data", wr_data, 64'h5A00 + 64'(i));
            check("s3_no_done", 64'(done), 64'd0);
            check("s3_busy", 64'(busy), 64'd1);
        end
        start = 1'b0;
        check("s3_ready_full", 64'(s_ready), 64'd0);
        check("s3_hr", 64'(hash_ready), 64'd1);
        s_valid = 1'b0;
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        check("s3_sim_hr", 64'(hash_ready), 64'd1);
        check("s3_sim_rd_bank", 64'(rd_bank), 64'd1);
        check("s3_sim_ready", 64'(s_ready), 64'd1);
        check("s3_sim_no_wr", 64'(wr_en), 64'd0);
        check("s3_sim_err", 64'(err), 64'd0);
        s_valid = 1'b1;
        s_data = 64'h5A10;
        step();
        s_valid = 1'b0;
        check("s3_next_wr_en", 64'(wr_en), 64'd1);
        check("s3_next_addr", 64'(wr_addr), 64'h100);
        check("s3_next_data", wr_data, 64'h5A10);

        // asynchronous reset mid-FILL
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 64'(busy), 64'd0);
        check("ar_hr", 64'(hash_ready), 64'd0);
        check("ar_rd_bank", 64'(rd_bank), 64'd0);
        check("ar_s_ready", 64'(s_ready), 64'd0);
        check("ar_wr_en", 64'(wr_en), 64'd0);
        check("ar_wr_addr", 64'(wr_addr), 64'd0);
        check("ar_wr_data", wr_data, 64'd0);
        check("ar_done", 64'(done), 64'd0);
        check("ar_err", 64'(err), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // fresh job after reset
        start = 1'b1; num_blocks = 10'd1;
        step();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = {32'hDEADBEEF, 32'(i)};
            step();
            check("pr_addr", 64'(wr_addr), 64'(32'h100 + i));
            check("pr_data", wr_data, {32'hDEADBEEF, 32'(i)});
        end
        s_valid = 1'b0;
        step();
        check("pr_hr", 64'(hash_ready), 64'd1);
        check("pr_rd_bank", 64'(rd_bank), 64'd0);
        block_done = 1'b1;
        step();
        block_done = 1'b0;
        step();
        check("pr_done", 64'(done), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/a_block_writer.md
Name: a_block_writer

Overview:
- Producer end of the HASH-RAM / `HASH_ready` handshake used by the AS matrix controller.
- Accepts a 64-bit stream of generated A-matrix words from the SHAKE/AES expander and writes them into a two-bank (ping-pong) region of the HASH BRAM.
- Raises `hash_ready` while at least one complete block is resident.
- Releases a bank when the consumer pulses `block_done`.

Parameters:
- WORDS_PER_ROW, 336, 64-bit words per A row (1344 coeffs x 16 bit / 64).
- ROWS_PER_BLOCK, 4, A rows per block (one systolic pass).
- BASE_ADDR, 0, word address of bank 0 in HASH RAM.
- ADDR_W, 32, address width.
- BANK_WORDS, WORDS_PER_ROW*ROWS_PER_BLOCK, words per bank (derived, 1344 by default).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin job; ignored while busy
- num_blocks  in  10  blocks in job, sampled on start; 0 = finish immediately
- s_valid  in  1  stream word valid
- s_data  in  64  stream word
- s_ready  out  1  stream accept
- wr_en  out  1  HASH RAM write enable
- wr_addr  out  ADDR_W  HASH RAM word address
- wr_data  out  64  HASH RAM write data
- hash_ready  out  1  at least one full bank is readable
- rd_bank  out  1  bank the consumer must read
- block_done  in  1  pulse from consumer: current rd_bank released
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky: block_done received with no full bank; cleared on start

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; wr_bank = rd_bank = 0; full_cnt = 0; counters 0.
  - Reset mid-job aborts the job and discards bank contents.
- FSM states:
  - IDLE:
    - start with num_blocks == 0 -> done pulses next cycle, stays IDLE.
    - start with num_blocks != 0 -> FILL; clear counters, wr_bank, rd_bank and err.
  - FILL:
    - s_ready = (full_cnt < 2).
    - Each handshake (s_valid && s_ready) writes one word.
    - After the last word of block num_blocks-1 is accepted -> WAIT; s_ready is 0 from the next cycle.
  - WAIT: once full_cnt == 0 -> IDLE with a done pulse.
  - busy = (state != IDLE).
- Write path, 1-cycle latency:
  - A handshake at edge E drives wr_en = 1, wr_data = s_data, wr_addr = BASE_ADDR + wr_bank*BANK_WORDS + word_idx for the cycle after E.
  - word_idx counts 0..BANK_WORDS-1 within the bank.
  - Row-major order: word_idx = row*WORDS_PER_ROW + col.
  - wr_en is 0 when there is no handshake.
- Bank completion:
  - On the edge after the write of word_idx == BANK_WORDS-1: full_cnt increments, wr_bank toggles, word_idx returns to 0, blocks_written increments.
  - hash_ready therefore rises no earlier than one cycle after the final write is presented to the RAM.
- Release:
  - block_done with full_cnt > 0: full_cnt decrements and rd_bank toggles.
  - block_done with full_cnt == 0: ignored, err set.
- Simultaneous completion and block_done in the same edge: full_cnt unchanged; both wr_bank and rd_bank toggle.
- hash_ready = (full_cnt != 0), registered-state derived, no combinational path from block_done.
- Back-pressure: with both banks full, s_ready = 0; s_data is never dropped or duplicated.
- start during busy: no effect.
- Counters are sized so that full_cnt never exceeds 2 and blocks_written never exceeds num_blocks.

Optional Feature:
- Macro A_BLOCK_WRITER_PERF_EN:
  - Adds output port stall_cnt (32 bit).
  - stall_cnt counts cycles with state == FILL, s_valid = 1 and s_ready = 0.
  - Cleared on an accepted start; saturates at all-ones.
- Without the macro: port and logic are absent; all other behaviour is identical.

Test Plan (WORDS_PER_ROW=4, ROWS_PER_BLOCK=2, so BANK_WORDS=8; BASE_ADDR=0x100 unless noted):
- Single block, continuous valid, data 0..7:
  - wr_addr 0x100..0x107 on consecutive cycles, each one cycle after its handshake.
  - hash_ready rises the cycle after the 0x107 write.
  - block_done -> done pulse one cycle later; busy falls.
- Three blocks, block_done withheld:
  - Bank 0 (0x100..) then bank 1 (0x108..) fill; s_ready drops after word 16.
  - s_valid held high: no writes until block_done; the next write goes to 0x100 with data 16; rd_bank = 1 after the release.
- Simultaneous event:
  - block_done pulsed on the same edge that completes bank 1 while full_cnt = 1.
  - full_cnt stays 1; rd_bank = 1, wr_bank = 0; hash_ready stays high.
- Error and ignore:
  - block_done in IDLE -> err = 1; a start pulse clears err.
  - A start asserted mid-FILL does not reset counters or addresses.
- num_blocks = 0 -> done pulse next cycle, no wr_en, busy stays 0. Reset asserted mid-FILL -> all outputs 0 asynchronously; a following job starts at 0x100.
- With A_BLOCK_WRITER_PERF_EN: in the three-blocks scenario, s_valid held 5 cycles while full -> stall_cnt = 5.
